// File: rtl/risci_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : risci_scoreboard
// Purpose  : Register-hazard scoreboard for the risci pipeline. Keeps a
//            saturating count of outstanding writes per architectural
//            register, so several in-flight writers to one register are legal.
//            Decode asks "may this instruction issue?"; writeback retires
//            pending writes, up to NCLR per cycle.
// Ports    : clk        - clock, all state updates on the rising edge
//            rst        - asynchronous, active-low reset
//            iss_valid  - decode presents an instruction
//            iss_rs     - NSRC source indices, slot k at [k*XWDT +: XWDT]
//            iss_rs_en  - per-slot source enable
//            iss_rd_en  - instruction writes a destination
//            iss_rd     - destination index
//            iss_ready  - combinational: issue accepted when valid & ready
//            wb_valid   - per-port writeback clear strobe
//            wb_rd      - per-port retired register index
//            flush      - synchronous clear of every counter
//            busy       - bit r set while register r has pending writes
//            err        - sticky: clear underflow or issue overflow seen
// Revision : 1.0 - initial release
// ============================================================================
module risci_scoreboard #(
  parameter int XN       = 64,
  parameter int XWDT     = 6,
  parameter int NSRC     = 3,
  parameter int NCLR     = 2,
  parameter int MAXPEND  = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic [NSRC*XWDT-1:0]   iss_rs,
  input  logic [NSRC-1:0]        iss_rs_en,
  input  logic                   iss_rd_en,
  input  logic [XWDT-1:0]        iss_rd,
  output logic                   iss_ready,
  input  logic [NCLR-1:0]        wb_valid,
  input  logic [NCLR*XWDT-1:0]   wb_rd,
  input  logic                   flush,
  output logic [XN-1:0]          busy,
  output logic                   err
);

  localparam int c_CW = $clog2(MAXPEND + 1);   // counter width
  localparam int c_DW = $clog2(NCLR + 1);      // per-cycle decrement width
  localparam int c_SW = c_CW + c_DW + 1;       // headroom for count+inc-dec

  logic [c_CW-1:0] w_cnt [XN];
  logic [XN-1:0]   w_hit;      // some writeback port retires register r
  logic [XN-1:0]   w_unf;
  logic [XN-1:0]   w_ovf;
  logic            w_src_stall;
  logic            w_dst_stall;
  logic            w_accept;
  logic            r_err;

  // ---------------------------------------------------------------------------
  // Per-register counter
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < XN; r++) begin : g_reg
    localparam logic [XWDT-1:0] c_IDX   = XWDT'(r);
    localparam bit              c_TRACK = !((ZERO_REG != 0) && (r == 0));

    logic [c_CW-1:0] r_cnt;
    logic [c_DW-1:0] w_dec;
    logic            w_inc;
    logic [c_SW-1:0] w_up;
    logic [c_SW-1:0] w_dn;
    logic [c_SW-1:0] w_diff;
    logic [c_CW-1:0] w_next;

    // Duplicate clears on several ports each count.
    always_comb begin
      w_dec = '0;
      for (int j = 0; j < NCLR; j++) begin
        if (c_TRACK && wb_valid[j] && (wb_rd[j*XWDT +: XWDT] == c_IDX)) begin
          w_dec = w_dec + c_DW'(1);
        end
      end
    end

    assign w_inc    = c_TRACK && w_accept && iss_rd_en && (iss_rd == c_IDX);
    assign w_up     = c_SW'(r_cnt) + c_SW'(w_inc);
    assign w_dn     = c_SW'(w_dec);
    assign w_diff   = w_up - w_dn;
    assign w_unf[r] = (w_dn > w_up);
    assign w_ovf[r] = !w_unf[r] && (w_diff > c_SW'(MAXPEND));
    // Saturate both ways; the error flag records that it happened.
    assign w_next   = w_unf[r] ? '0 :
                      w_ovf[r] ? c_CW'(MAXPEND) : w_diff[c_CW-1:0];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (flush) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_next;
      end
    end

    assign w_cnt[r] = r_cnt;
    assign w_hit[r] = (w_dec != '0);
    assign busy[r]  = (r_cnt != '0);
  end

  // ---------------------------------------------------------------------------
  // Issue check
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [XWDT-1:0] w_idx;
    w_src_stall = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NSRC; k++) begin
      w_idx = iss_rs[k*XWDT +: XWDT];
      if (iss_rs_en[k] && (int'(w_idx) < XN) &&
          !((ZERO_REG != 0) && (w_idx == '0))) begin
        // Bypass: the last pending write retiring now makes the source ready.
        if ((w_cnt[w_idx] != '0) &&
            !((BYPASS != 0) && (w_cnt[w_idx] == c_CW'(1)) && w_hit[w_idx])) begin
          w_src_stall = 1'b1;
        end
      end
    end
  end

  // A same-cycle clear of the destination frees a slot, so a full counter
  // only stalls when nothing retires it this cycle.
  always_comb begin
    w_dst_stall = 1'b0;
    if (iss_rd_en && (int'(iss_rd) < XN) &&
        !((ZERO_REG != 0) && (iss_rd == '0))) begin
      if ((w_cnt[iss_rd] == c_CW'(MAXPEND)) && !w_hit[iss_rd]) begin
        w_dst_stall = 1'b1;
      end
    end
  end

  assign iss_ready = !flush && !w_src_stall && !w_dst_stall;
  assign w_accept  = iss_valid && iss_ready;

  // ---------------------------------------------------------------------------
  // Sticky error; flushed traffic is discarded and cannot raise it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (!flush && ((|w_unf) || (|w_ovf))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_risci_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_risci_scoreboard
// Purpose  : Directed self-checking bench for risci_scoreboard. Expected
//            values are queued when stimulus is driven and popped against the
//            DUT output when it is produced. A second instance with BYPASS=0
//            shares the stimulus for the writeback-bypass timing check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risci_scoreboard;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [17:0] iss_rs;
  logic [2:0]  iss_rs_en;
  logic        iss_rd_en;
  logic [5:0]  iss_rd;
  logic        iss_ready;
  logic        nb_ready;
  logic [1:0]  wb_valid;
  logic [11:0] wb_rd;
  logic        flush;
  logic [63:0] busy;
  logic [63:0] nb_busy;
  logic        err;
  logic        nb_err;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  risci_scoreboard dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rs(iss_rs),
    .iss_rs_en(iss_rs_en), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd),
    .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .busy(busy), .err(err)
  );

  risci_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rs(iss_rs),
    .iss_rs_en(iss_rs_en), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd),
    .iss_ready(nb_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .busy(nb_busy), .err(nb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] bit_of(input int r);
    logic [63:0] one;
    one = 64'd1;
    return one << r;
  endfunction

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_bad++;
      $error("FAIL queue_underrun observed=%h required=<queued value>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [5:0] s0, input logic [5:0] s1,
                     input logic [5:0] s2, input logic [2:0] sen,
                     input logic rde, input logic [5:0] rd,
                     input logic [1:0] wbv, input logic [5:0] w0,
                     input logic [5:0] w1, input logic fl);
    iss_valid = v;
    iss_rs    = {s2, s1, s0};
    iss_rs_en = sen;
    iss_rd_en = rde;
    iss_rd    = rd;
    wb_valid  = wbv;
    wb_rd     = {w1, w0};
    flush     = fl;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic exp_ready(input string tag, input logic e);
    push(tag, {63'd0, e});
    pop_chk({63'd0, iss_ready});
  endtask

  task automatic exp_nb_ready(input string tag, input logic e);
    push(tag, {63'd0, e});
    pop_chk({63'd0, nb_ready});
  endtask

  task automatic exp_busy(input string tag, input logic [63:0] e);
    push(tag, e);
    pop_chk(busy);
  endtask

  task automatic exp_err(input string tag, input logic e);
    push(tag, {63'd0, e});
    pop_chk({63'd0, err});
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #12;
    exp_busy("reset_busy", 64'd0);
    exp_err("reset_err", 1'b0);
    exp_ready("reset_ready", 1'b1);
    rst = 1'b1;
    tick();

    // Issue rd=5 reading r1,r2.
    drv(1'b1, 6'd1, 6'd2, 6'd0, 3'b011, 1'b1, 6'd5, 2'b00, 6'd0, 6'd0, 1'b0);
    exp_ready("iss_rd5_ready", 1'b1);
    push("busy_r5_set", bit_of(5));
    tick();
    pop_chk(busy);

    // Dependent on r5 stalls until r5 retires.
    drv(1'b1, 6'd5, 6'd0, 6'd0, 3'b001, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0);
    exp_ready("raw_r5_stall", 1'b0);
    exp_nb_ready("raw_r5_stall_nb", 1'b0);
    tick();
    drv(1'b1, 6'd5, 6'd0, 6'd0, 3'b001, 1'b0, 6'd0, 2'b01, 6'd5, 6'd0, 1'b0);
    exp_ready("raw_r5_bypass", 1'b1);
    exp_nb_ready("raw_r5_nobypass", 1'b0);
    push("busy_r5_clear", 64'd0);
    tick();
    pop_chk(busy);
    drv(1'b1, 6'd5, 6'd0, 6'd0, 3'b001, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0);
    exp_ready("raw_r5_after", 1'b1);
    exp_nb_ready("raw_r5_after_nb", 1'b1);
    tick();

    // Three writers to r7 fill the counter.
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd7, 2'b00, 6'd0, 6'd0, 1'b0);
      exp_ready($sformatf("fill_r7_%0d", i), 1'b1);
      push($sformatf("fill_r7_busy_%0d", i), bit_of(7));
      tick();
      pop_chk(busy);
    end
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd7, 2'b00, 6'd0, 6'd0, 1'b0);
    exp_ready("full_r7_stall", 1'b0);
    tick();
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd7, 2'b01, 6'd7, 6'd0, 1'b0);
    exp_ready("full_r7_clr_frees", 1'b1);
    tick();
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd7, 2'b00, 6'd0, 6'd0, 1'b0);
    exp_ready("full_r7_still3", 1'b0);
    // Two clears in one cycle: 3 -> 1.
    drv(1'b0, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 6'd0, 2'b11, 6'd7, 6'd7, 1'b0);
    push("r7_after_dual_clr", bit_of(7));
    tick();
    pop_chk(busy);
    drv(1'b1, 6'd7, 6'd0, 6'd0, 3'b001, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0);
    exp_ready("r7_count1_stall", 1'b0);
    drv(1'b0, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 6'd0, 2'b01, 6'd7, 6'd0, 1'b0);
    push("r7_drained", 64'd0);
    tick();
    pop_chk(busy);

    // r9: same-cycle issue and clear, then a duplicate clear to zero.
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd9, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd9, 2'b01, 6'd9, 6'd0, 1'b0);
    exp_ready("r9_iss_and_clr", 1'b1);
    push("r9_net_zero", bit_of(9));
    tick();
    pop_chk(busy);
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd9, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    drv(1'b0, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 6'd0, 2'b11, 6'd9, 6'd9, 1'b0);
    push("r9_dual_clr_busy", 64'd0);
    push("r9_dual_clr_err", 64'd0);
    tick();
    pop_chk(busy);
    pop_chk({63'd0, err});

    // Underflow on r12 sets a sticky error.
    drv(1'b0, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 6'd0, 2'b01, 6'd12, 6'd0, 1'b0);
    tick();
    exp_err("underflow_err", 1'b1);
    exp_busy("underflow_busy", 64'd0);
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd3, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    exp_err("err_sticky", 1'b1);

    // r0 is never tracked; fully disabled issue is always ready.
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b111, 1'b1, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0);
    exp_ready("zero_reg_ready", 1'b1);
    tick();
    exp_busy("zero_reg_busy", bit_of(3));
    drv(1'b1, 6'd3, 6'd3, 6'd3, 3'b000, 1'b0, 6'd3, 2'b00, 6'd0, 6'd0, 1'b0);
    exp_ready("all_disabled_ready", 1'b1);
    tick();

    // Fill r4 next to r3, then flush alongside a valid issue.
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd4, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    exp_busy("r3_r4_busy", bit_of(3) | bit_of(4));
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd6, 2'b00, 6'd0, 6'd0, 1'b1);
    exp_ready("flush_ready_low", 1'b0);
    tick();
    exp_busy("flush_busy", 64'd0);
    exp_err("flush_keeps_err", 1'b1);

    // Asynchronous reset mid-stream.
    drv(1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b1, 6'd8, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    exp_busy("r8_busy", bit_of(8));
    idle();
    rst = 1'b0;
    #1;
    exp_busy("async_rst_busy", 64'd0);
    exp_err("async_rst_err", 1'b0);
    #2;
    rst = 1'b1;
    tick();

    // Clear to r0 is ignored, so it cannot underflow.
    drv(1'b0, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 6'd0, 2'b01, 6'd0, 6'd0, 1'b0);
    tick();
    exp_err("r0_clear_no_err", 1'b0);
    drv(1'b1, 6'd8, 6'd0, 6'd0, 3'b001, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0);
    exp_ready("r8_free_after_rst", 1'b1);
    tick();
    idle();

    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL queue_leftover observed=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risci_scoreboard.md
Name: risci_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the risci pipeline. Successor to the single-bit set/clear register lock.
- Tracks a saturating count of outstanding writes per architectural register, so several in-flight writers to one register are allowed.
- Checks up to NSRC sources plus one destination per issue in one cycle, and accepts NCLR writeback clears per cycle.
- Sits between decode (issue side) and writeback (clear side).

Parameters:
- XN, 64, number of architectural registers.
- XWDT, 6, register index width; XN <= 2**XWDT.
- NSRC, 3, source operands checked per issue.
- NCLR, 2, writeback clear ports.
- MAXPEND, 3, maximum outstanding writes per register; counter width CW = clog2(MAXPEND+1).
- BYPASS, 1, if 1 a source whose last pending write clears this cycle counts as ready.
- ZERO_REG, 1, if 1 register 0 is never tracked: always ready, issues to it ignored.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- iss_valid  in  1  decode presents an instruction.
- iss_rs  in  NSRC*XWDT  source indices; slot k = bits [k*XWDT +: XWDT].
- iss_rs_en  in  NSRC  per-slot enable; disabled slots never stall.
- iss_rd_en  in  1  instruction writes a destination.
- iss_rd  in  XWDT  destination index.
- iss_ready  out  1  combinational; issue accepted this cycle when iss_valid & iss_ready.
- wb_valid  in  NCLR  per-port clear strobe.
- wb_rd  in  NCLR*XWDT  per-port register being retired.
- flush  in  1  synchronous; zeroes all counters.
- busy  out  XN  registered; bit r = (count[r] != 0).
- err  out  1  registered, sticky until reset: clear underflow or issue overflow was attempted.

Behaviour:
- Reset (rst=0, asynchronous): all counters 0, busy = 0, err = 0. iss_ready then follows the combinational rule below.
- Source k stalls when all of the following hold:
  - iss_rs_en[k] = 1;
  - the register is not r0 while ZERO_REG=1;
  - count[iss_rs[k]] != 0;
  - it is NOT the case that BYPASS=1 and count = 1 and some wb_valid[j] hits that register this cycle.
- Destination stalls when iss_rd_en = 1 and count[iss_rd] = MAXPEND and no clear hits iss_rd this cycle. A clear on the same cycle frees a slot.
- iss_ready = !flush && no source stalls && destination does not stall. iss_ready is independent of iss_valid.
- Per register r each cycle:
  - inc = issue accepted & iss_rd_en & iss_rd == r & !(ZERO_REG && r == 0);
  - dec = number of wb ports hitting r;
  - next = count + inc − dec.
- Simultaneous issue and clear of the same register: net change applied in the same edge, no stall cycle.
- Duplicate clears: two wb ports naming the same register in one cycle decrement by 2.
- Underflow: when dec > count + inc, the counter saturates at 0 and err sets on the next edge.
- Overflow: cannot occur through a legal handshake. If count + inc − dec > MAXPEND (issue without honouring iss_ready), the counter holds MAXPEND and err sets.
- ZERO_REG=1: count[0] stays 0, and clears to r0 are ignored (no err).
- Indices >= XN on any port are ignored for counting. Such a source never stalls.
- flush=1: all counters go to 0 on the next edge; same-cycle issues and clears are discarded; err is unaffected. iss_ready=0 during flush.
- Latency:
  - iss_ready is combinational from inputs and current counts;
  - counts and busy update one edge after the event;
  - a clear is visible to dependents the same cycle only when BYPASS=1, otherwise on the next cycle.
- rst assertion mid-operation: counters clear immediately; on rst release, the first edge behaves as from idle.

Test Plan:
- Reset, then issue rd=5 with srcs r1,r2: iss_ready=1; next cycle busy[5]=1. An issue reading r5 then gets iss_ready=0 until wb_valid[0] with wb_rd=5. With BYPASS=1, iss_ready=1 in that same cycle; with BYPASS=0, one cycle later. busy[5]=0 afterwards.
- Three back-to-back issues to rd=7 (MAXPEND=3): all accepted and count reaches 3; a 4th is held with iss_ready=0. A simultaneous wb of r7 lets the 4th issue with count staying 3; two more clears leave count 1 and busy[7]=1.
- Same-cycle issue rd=9 and wb_rd=9 with count=1: count stays 1, no stall. Two wb ports both on r9 with count=2: count becomes 0.
- wb on r12 with count 0: err=1 next cycle and remains 1 through further traffic until rst=0.
- Issue rd=0 and a source r0 with ZERO_REG=1: never stalls, busy[0]=0. Issue with all iss_rs_en=0 and iss_rd_en=0: always ready.
- Fill r3 and r4, then pulse flush alongside a valid issue: iss_ready=0 during flush; next cycle busy=0 and the issue is not recorded. Assert rst mid-stream: busy=0 and err=0 immediately, without waiting for a clock edge.
